boot_imem_loader: RTL
=====================

Name: boot_imem_loader

Overview:
- Instruction memory with a byte-stream boot loader, sitting directly upstream of the single-cycle core.
- After reset it accepts a program image over a valid/ready byte stream and writes it into word memory, holding the core in reset meanwhile.
- Once the image is loaded, it releases the core and serves instructions combinationally, indexed by the core's PC.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words.
- ADDR_W, 8, word-index width; must satisfy 2**ADDR_W == DEPTH_WORDS.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- rx_valid  input  1  byte-stream valid.
- rx_byte  input  8  byte-stream data.
- rx_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  single-cycle pulse; restarts loading from RUN or ERROR.
- PC  input  32  fetch address from the core.
- instr  output  32  instruction to the core.
- core_hold  output  1  1 = hold core in reset.
- boot_done  output  1  image loaded, core running.
- boot_err  output  1  image length exceeds DEPTH_WORDS.
- word_count  output  16  latched image length N.

Behaviour:
- Reset is asynchronous and active-low: reset=0 forces the state below immediately; it is released synchronously on clk.
  - state=LEN_LO; byte index, word index, shift register and word_count all cleared.
  - core_hold=1, boot_done=0, boot_err=0, rx_ready=1.
  - Memory contents are NOT cleared.
- Byte transfer: a byte transfers on a rising edge with rx_valid && rx_ready. rx_valid without rx_ready is ignored; no byte is lost or duplicated.
- Image format: 16-bit little-endian word count N, then N words, each 4 bytes little-endian (first byte goes to bits [7:0]).
- State machine:
  - LEN_LO: rx_ready=1. Transfer latches word_count[7:0] -> LEN_HI.
  - LEN_HI: rx_ready=1. Transfer latches word_count[15:8] -> CHECK.
  - CHECK (exactly 1 cycle, rx_ready=0):
    - N==0 -> RUN.
    - N>DEPTH_WORDS -> ERROR.
    - Otherwise -> DATA, with word index=0 and byte index=0.
  - DATA: rx_ready=1. Each transfer shifts the byte into the assembly register and increments the 2-bit byte index.
    - On the 4th byte, the assembled word is written to mem[word index] on that same edge and the word index increments.
    - If that word was index N-1 -> RUN.
  - RUN: rx_ready=0, core_hold=0, boot_done=1. reload=1 -> LEN_LO (core_hold=1 and boot_done=0 from the next cycle).
  - ERROR: rx_ready=0, core_hold=1, boot_err=1. reload=1 -> LEN_LO and boot_err clears.
- reload is ignored in LEN_LO, LEN_HI, CHECK and DATA.
- Fetch:
  - In RUN: instr = mem[PC[ADDR_W+1:2]], combinational with zero-cycle latency.
  - PC[1:0] is ignored. PC bits above ADDR_W+1 are ignored, so out-of-range addresses wrap.
  - Outside RUN: instr = 32'h00000013 (NOP).
- Memory write and read: one write port (loader only) and one asynchronous read port. Writes occur only in DATA; the core never writes.
- Partial image: words beyond N retain their previous contents.
- Reset mid-load: the load aborts and restarts at LEN_LO with no partial-word write. Words already written remain in memory.
- Stalled stream: the loader waits indefinitely in any receiving state; there is no timeout.

Test Plan:
- Reset release, stream 02 00 | 13 05 10 00 | 93 05 20 00 -> mem[0]=32'h00100513, mem[1]=32'h00200593. core_hold falls and boot_done rises the cycle after the 10th byte. PC=4 -> instr=32'h00200593.
- Same image with rx_valid toggled every other cycle and rx_ready checked in CHECK (0) -> identical memory, one byte per accepted handshake, no duplicates.
- Length 01 01 (N=257, DEPTH_WORDS=256) -> ERROR, boot_err=1, core_hold=1, rx_ready=0. reload pulse -> LEN_LO, boot_err=0, then a valid 1-word image loads and reaches RUN.
- Length 00 00 -> RUN two cycles after the 2nd byte. instr reflects existing memory; no writes occur.
- Assert reset after 3 bytes of word 1 in a 3-word load -> state LEN_LO, core_hold=1, instr=32'h00000013. mem[0] keeps its new value; mem[1] is unchanged.
- In RUN, PC=32'h00000403 with DEPTH_WORDS=256 -> instr=mem[0] (wrap, low bits ignored). reload pulse -> instr=32'h00000013 on the next cycle.

Source files
------------

// File: rtl/boot_imem_loader.sv
// Instruction memory with a length-prefixed byte-stream boot loader.
// Holds the core in reset until the image is written, then serves fetches by PC.
module boot_imem_loader #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        rx_ready,
   input  logic        reload,
   input  logic [31:0] PC,
   output logic [31:0] instr,
   output logic        core_hold,
   output logic        boot_done,
   output logic        boot_err,
   output logic [15:0] word_count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   if (DEPTH_WORDS != (1 << ADDR_W)) begin : g_cfg_check
      $error("boot_imem_loader: DEPTH_WORDS must equal 2**ADDR_W");
   end

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_CHECK,
      S_DATA,
      S_RUN,
      S_ERROR
   } state_t;

   state_t            r_state;
   logic [1:0]        r_byte_idx;
   logic [ADDR_W-1:0] r_word_idx;
   logic [23:0]       r_shift;
   logic [15:0]       r_word_count;
   logic              r_rx_ready;
   logic              r_core_hold;
   logic              r_boot_done;
   logic              r_boot_err;
   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_xfer;
   logic              w_word_wr;
   logic              w_last_word;
   logic              w_len_too_big;
   logic [31:0]       w_word;
   logic [ADDR_W-1:0] w_fetch_idx;
   logic              w_unused_pc;

   assign w_xfer        = rx_valid && r_rx_ready;
   assign w_word_wr     = w_xfer && (r_state == S_DATA) && (r_byte_idx == 2'd3);
   // Earlier bytes sit in r_shift with the oldest at the bottom, so the
   // fourth byte completes a little-endian word without further shuffling.
   assign w_word        = {rx_byte, r_shift};
   assign w_last_word   = (32'(r_word_idx) == (32'(r_word_count) - 32'd1));
   assign w_len_too_big = (32'(r_word_count) > 32'(DEPTH_WORDS));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_LEN_LO;
         r_byte_idx   <= 2'd0;
         r_word_idx   <= '0;
         r_shift      <= 24'd0;
         r_word_count <= 16'd0;
         r_rx_ready   <= 1'b1;
         r_core_hold  <= 1'b1;
         r_boot_done  <= 1'b0;
         r_boot_err   <= 1'b0;
      end else begin
         case (r_state)
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_word_count[7:0] <= rx_byte;
                  r_state           <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_word_count[15:8] <= rx_byte;
                  r_state            <= S_CHECK;
                  r_rx_ready         <= 1'b0;
               end
            end
            S_CHECK: begin
               if (r_word_count == 16'd0) begin
                  r_state     <= S_RUN;
                  r_core_hold <= 1'b0;
                  r_boot_done <= 1'b1;
               end else if (w_len_too_big) begin
                  r_state    <= S_ERROR;
                  r_boot_err <= 1'b1;
               end else begin
                  r_state    <= S_DATA;
                  r_byte_idx <= 2'd0;
                  r_word_idx <= '0;
                  r_rx_ready <= 1'b1;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_shift    <= w_word[31:8];
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_word_idx <= r_word_idx + ADDR_W'(1);
                     if (w_last_word) begin
                        r_state     <= S_RUN;
                        r_rx_ready  <= 1'b0;
                        r_core_hold <= 1'b0;
                        r_boot_done <= 1'b1;
                     end
                  end
               end
            end
            S_RUN: begin
               if (reload) begin
                  r_state     <= S_LEN_LO;
                  r_rx_ready  <= 1'b1;
                  r_core_hold <= 1'b1;
                  r_boot_done <= 1'b0;
               end
            end
            S_ERROR: begin
               if (reload) begin
                  r_state    <= S_LEN_LO;
                  r_rx_ready <= 1'b1;
                  r_boot_err <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_LEN_LO;
               r_rx_ready  <= 1'b1;
               r_core_hold <= 1'b1;
               r_boot_done <= 1'b0;
               r_boot_err  <= 1'b0;
            end
         endcase
      end
   end

   // Memory has no reset so a reload or core reset keeps the previous image.
   always_ff @(posedge clk) begin
      if (w_word_wr) begin
         r_mem[r_word_idx] <= w_word;
      end
   end

   assign w_fetch_idx = PC[ADDR_W+1:2];
   assign w_unused_pc = ^{PC[31:ADDR_W+2], PC[1:0]};
   assign instr       = (r_state == S_RUN) ? r_mem[w_fetch_idx] : NOP;

   assign rx_ready   = r_rx_ready;
   assign core_hold  = r_core_hold;
   assign boot_done  = r_boot_done;
   assign boot_err   = r_boot_err;
   assign word_count = r_word_count;

endmodule
